// File: rtl/vga_timing_if.sv
// Video-side bundle of the VGA timing generator: raster position, strobes,
// syncs and the colour path to and from the renderer.
interface vga_timing_if #(
  parameter int RGB_W = 3
);
  logic             pix_ce;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             de;
  logic             line_strobe;
  logic             frame_strobe;
  logic [RGB_W-1:0] pixel_rgb;
  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] rgb;

  modport master (
    output pix_ce, x, y, de, line_strobe, frame_strobe, hsync, vsync, rgb,
    input  pixel_rgb
  );

  modport slave (
    input  pix_ce, x, y, de, line_strobe, frame_strobe, hsync, vsync, rgb,
    output pixel_rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock prescaler,
// programmable sync polarity and renderer-latency compensation.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 1,
  parameter int LATENCY  = 0,
  parameter int RGB_W    = 3
) (
  input logic          clk,
  input logic          reset,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic        HS_ON    = 1'(H_POL);
  localparam logic        VS_ON    = 1'(V_POL);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (LATENCY < 0 || LATENCY > 7) begin : g_bad_lat
      $error("vga_timing_gen: LATENCY must be 0..7");
    end
  endgenerate

  logic [3:0]       div_q, div_d;
  logic             pix_ce_q, pix_ce_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic             de_raw, hs_raw, vs_raw;
  logic [2:0]       raw_vec, del_vec;

  // Prescaler and raster counters; the strobe is registered so x/y step on the clk after the divider wraps.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    pix_ce_d = (div_q == DIV_LAST);
    x_d      = x_q;
    y_d      = y_q;
    if (pix_ce_q) begin
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  assign de_raw  = ({1'b0, x_q} < H_ACT) && ({1'b0, y_q} < V_ACT);
  assign hs_raw  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
  assign vs_raw  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
  assign raw_vec = {hs_raw, vs_raw, de_raw};

  generate
    if (LATENCY == 0) begin : g_no_delay
      assign del_vec = raw_vec;
    end else begin : g_delay
      logic [2:0] sr_q [LATENCY];
      logic [2:0] sr_d [LATENCY];

      // Shift the {hsync, vsync, enable} triple one stage per pixel tick to match renderer latency.
      always_comb begin
        sr_d = sr_q;
        if (pix_ce_q) begin
          sr_d[0] = raw_vec;
          for (int i = 1; i < LATENCY; i++) begin
            sr_d[i] = sr_q[i-1];
          end
        end
      end

      // Delay-line storage, cleared to inactive syncs and blanked enable.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < LATENCY; i++) begin
            sr_q[i] <= 3'b000;
          end
        end else begin
          sr_q <= sr_d;
        end
      end

      assign del_vec = sr_q[LATENCY-1];
    end
  endgenerate

  // Final output stage: apply sync polarity and blank colour outside the delayed active area.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_ce_q) begin
      hsync_d = del_vec[2] ? HS_ON : ~HS_ON;
      vsync_d = del_vec[1] ? VS_ON : ~VS_ON;
      rgb_d   = del_vec[0] ? vif.pixel_rgb : '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q    <= 4'd0;
      pix_ce_q <= 1'b0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      hsync_q  <= ~HS_ON;
      vsync_q  <= ~VS_ON;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      rgb_q    <= rgb_d;
    end
  end

  assign vif.pix_ce       = pix_ce_q;
  assign vif.x            = x_q;
  assign vif.y            = y_q;
  assign vif.de           = de_raw;
  assign vif.line_strobe  = pix_ce_q && (x_q == H_LAST);
  assign vif.frame_strobe = pix_ce_q && (x_q == H_LAST) && (y_q == V_LAST);
  assign vif.hsync        = hsync_q;
  assign vif.vsync        = vsync_q;
  assign vif.rgb          = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (default horizontal timing at full
// pixel rate, and a small prescaled/delayed positive-polarity raster) checked
// every clk against an arithmetic model of the raster, plus literal pins.
module tb_vga_timing_gen;

  // Instance 0: default horizontal timing, short frame so several frames fit.
  localparam int C0_HA = 640, C0_HF = 24, C0_HS = 40, C0_HB = 128;
  localparam int C0_VA = 6,   C0_VF = 1,  C0_VS = 1,  C0_VB = 1;
  localparam int C0_D  = 1,   C0_L  = 0,  C0_HP = 0,  C0_VP = 0;
  // Instance 1: prescaled, delayed, positive syncs.
  localparam int C1_HA = 8,   C1_HF = 2,  C1_HS = 2,  C1_HB = 2;
  localparam int C1_VA = 4,   C1_VF = 1,  C1_VS = 1,  C1_VB = 1;
  localparam int C1_D  = 4,   C1_L  = 3,  C1_HP = 1,  C1_VP = 1;

  typedef struct {
    int pix, x, y, de, ls, fs, hs, vs, rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] pix_rgb = 3'b000;

  int checks = 0;
  int passes = 0;
  bit checking = 1'b0;

  int edges = 0;
  int samp0 = 0;
  int samp1 = 0;
  exp_t ex0, ex1;

  vga_timing_if #(.RGB_W(3)) if0 ();
  vga_timing_if #(.RGB_W(3)) if1 ();
  assign if0.pixel_rgb = pix_rgb;
  assign if1.pixel_rgb = pix_rgb;

  vga_timing_gen #(
    .H_ACTIVE(C0_HA), .H_FP(C0_HF), .H_SYNC(C0_HS), .H_BP(C0_HB),
    .V_ACTIVE(C0_VA), .V_FP(C0_VF), .V_SYNC(C0_VS), .V_BP(C0_VB),
    .H_POL(C0_HP), .V_POL(C0_VP), .CLK_DIV(C0_D), .LATENCY(C0_L), .RGB_W(3)
  ) dut0 (
    .clk(clk), .reset(reset), .vif(if0)
  );

  vga_timing_gen #(
    .H_ACTIVE(C1_HA), .H_FP(C1_HF), .H_SYNC(C1_HS), .H_BP(C1_HB),
    .V_ACTIVE(C1_VA), .V_FP(C1_VF), .V_SYNC(C1_VS), .V_BP(C1_VB),
    .H_POL(C1_HP), .V_POL(C1_VP), .CLK_DIV(C1_D), .LATENCY(C1_L), .RGB_W(3)
  ) dut1 (
    .clk(clk), .reset(reset), .vif(if1)
  );

  always #5 clk = ~clk;

  // Expected outputs after 'e' edges out of reset: tick count is floor((e-1)/D),
  // position is tick count modulo the raster, syncs/enable look L+1 ticks back.
  function automatic exp_t model(input int c, input int e, input int s);
    exp_t r;
    int ha, hf, hs, hb, va, vf, vs, vb, d, l, hp, vp;
    int ht, vt, t, td, xd, yd, hsA, vsA, deA;
    if (c == 0) begin
      ha = C0_HA; hf = C0_HF; hs = C0_HS; hb = C0_HB;
      va = C0_VA; vf = C0_VF; vs = C0_VS; vb = C0_VB;
      d = C0_D; l = C0_L; hp = C0_HP; vp = C0_VP;
    end else begin
      ha = C1_HA; hf = C1_HF; hs = C1_HS; hb = C1_HB;
      va = C1_VA; vf = C1_VF; vs = C1_VS; vb = C1_VB;
      d = C1_D; l = C1_L; hp = C1_HP; vp = C1_VP;
    end
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    t = (e >= 1) ? (e - 1) / d : 0;
    r.x   = t % ht;
    r.y   = (t / ht) % vt;
    r.pix = (e >= 1 && (e % d) == 0) ? 1 : 0;
    r.de  = (r.x < ha && r.y < va) ? 1 : 0;
    r.ls  = (r.pix == 1 && r.x == ht - 1) ? 1 : 0;
    r.fs  = (r.ls == 1 && r.y == vt - 1) ? 1 : 0;
    hsA = 0; vsA = 0; deA = 0;
    if (t >= l + 1) begin
      td = t - l - 1;
      xd = td % ht;
      yd = (td / ht) % vt;
      hsA = (xd >= ha + hf && xd < ha + hf + hs) ? 1 : 0;
      vsA = (yd >= va + vf && yd < va + vf + vs) ? 1 : 0;
      deA = (xd < ha && yd < va) ? 1 : 0;
    end
    r.hs  = (hsA == 1) ? hp : 1 - hp;
    r.vs  = (vsA == 1) ? vp : 1 - vp;
    r.rgb = (deA == 1) ? s : 0;
    return r;
  endfunction

  // Edge counter since reset and the renderer colour captured at each pixel tick.
  always @(posedge clk) begin
    if (!reset) begin
      edges <= 0;
    end else begin
      edges <= edges + 1;
      if (edges >= 1 && (edges % C0_D) == 0) samp0 <= int'(pix_rgb);
      if (edges >= 1 && (edges % C1_D) == 0) samp1 <= int'(pix_rgb);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic checkAll(input int c, input exp_t ex, input int pix, input int x, input int y,
                          input int de, input int ls, input int fs, input int hs,
                          input int vs, input int rgb);
    checkOutput($sformatf("dut%0d_pix_ce", c), pix, ex.pix);
    checkOutput($sformatf("dut%0d_x", c), x, ex.x);
    checkOutput($sformatf("dut%0d_y", c), y, ex.y);
    checkOutput($sformatf("dut%0d_de", c), de, ex.de);
    checkOutput($sformatf("dut%0d_line_strobe", c), ls, ex.ls);
    checkOutput($sformatf("dut%0d_frame_strobe", c), fs, ex.fs);
    checkOutput($sformatf("dut%0d_hsync", c), hs, ex.hs);
    checkOutput($sformatf("dut%0d_vsync", c), vs, ex.vs);
    checkOutput($sformatf("dut%0d_rgb", c), rgb, ex.rgb);
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      ex0 = model(0, edges, samp0);
      ex1 = model(1, edges, samp1);
      checkAll(0, ex0, int'(if0.pix_ce), int'(if0.x), int'(if0.y), int'(if0.de),
               int'(if0.line_strobe), int'(if0.frame_strobe), int'(if0.hsync),
               int'(if0.vsync), int'(if0.rgb));
      checkAll(1, ex1, int'(if1.pix_ce), int'(if1.x), int'(if1.y), int'(if1.de),
               int'(if1.line_strobe), int'(if1.frame_strobe), int'(if1.hsync),
               int'(if1.vsync), int'(if1.rgb));
    end
  end

  task automatic applyStimulus(input logic rst, input logic [2:0] p);
    reset   = rst;
    pix_rgb = p;
    @(negedge clk);
  endtask

  // Measurement state for the literal timing pins.
  int n = 0;
  bit pH0 = 1'b1, pV0 = 1'b1, pH1 = 1'b0, pV1 = 1'b0;
  int fallH0 = -1, fallV0 = -1, riseH1 = -1, riseV1 = -1;
  int lastFs0 = -1, lastFs1 = -1, lastLs1 = -1, lastPix1 = -1, frameStart1 = -1;
  int hPeriod0 = 0, hLow0 = 0, vLow0 = 0, fPeriod0 = 0, rgbCnt0 = 0, rgbFrame0 = 0;
  int hHigh1 = 0, vHigh1 = 0, linePeriod1 = 0, fPeriod1 = 0, pixGap1 = 0, lag1 = -1;
  int blankViol = 0;

  task automatic measureStep();
    @(negedge clk);
    n++;
    if (pH0 && !if0.hsync) begin
      if (fallH0 >= 0) hPeriod0 = n - fallH0;
      fallH0 = n;
    end
    if (!pH0 && if0.hsync && fallH0 >= 0) hLow0 = n - fallH0;
    if (pV0 && !if0.vsync) fallV0 = n;
    if (!pV0 && if0.vsync && fallV0 >= 0) vLow0 = n - fallV0;
    if (if0.rgb != 3'b000) rgbCnt0++;
    if (if0.frame_strobe) begin
      if (lastFs0 >= 0) begin
        fPeriod0  = n - lastFs0;
        rgbFrame0 = rgbCnt0;
      end
      lastFs0 = n;
      rgbCnt0 = 0;
    end
    if (!pH1 && if1.hsync) riseH1 = n;
    if (pH1 && !if1.hsync && riseH1 >= 0) hHigh1 = n - riseH1;
    if (!pV1 && if1.vsync) riseV1 = n;
    if (pV1 && !if1.vsync && riseV1 >= 0) vHigh1 = n - riseV1;
    if (if1.pix_ce) begin
      if (lastPix1 >= 0) pixGap1 = n - lastPix1;
      lastPix1 = n;
    end
    if (if1.line_strobe) begin
      if (lastLs1 >= 0) linePeriod1 = n - lastLs1;
      lastLs1 = n;
    end
    if (frameStart1 >= 0 && lag1 < 0 && if1.rgb != 3'b000) lag1 = n - frameStart1;
    if (if1.frame_strobe) begin
      if (lastFs1 >= 0) fPeriod1 = n - lastFs1;
      lastFs1 = n;
      if (lag1 < 0) frameStart1 = n + 1;
    end
    if (if0.rgb != 3'b000 && (!if0.hsync || !if0.vsync)) blankViol++;
    if (if1.rgb != 3'b000 && (if1.hsync || if1.vsync)) blankViol++;
    pH0 = if0.hsync; pV0 = if0.vsync; pH1 = if1.hsync; pV1 = if1.vsync;
  endtask

  initial begin
    bit found;

    // Reset held low for 50 clks.
    applyStimulus(1'b0, 3'b111);
    applyStimulus(1'b0, 3'b111);
    checking = 1'b1;
    repeat (48) applyStimulus(1'b0, 3'b111);
    checkOutput("rst_x0", int'(if0.x), 0);
    checkOutput("rst_y0", int'(if0.y), 0);
    checkOutput("rst_de0", int'(if0.de), 1);
    checkOutput("rst_pix_ce0", int'(if0.pix_ce), 0);
    checkOutput("rst_hsync0", int'(if0.hsync), 1);
    checkOutput("rst_vsync0", int'(if0.vsync), 1);
    checkOutput("rst_rgb0", int'(if0.rgb), 0);
    checkOutput("rst_hsync1", int'(if1.hsync), 0);
    checkOutput("rst_vsync1", int'(if1.vsync), 0);

    // Constant colour over two short frames while measuring timing.
    reset   = 1'b1;
    pix_rgb = 3'b101;
    repeat (16000) measureStep();
    checkOutput("hsync0_period", hPeriod0, 832);
    checkOutput("hsync0_low", hLow0, 40);
    checkOutput("vsync0_low_clks", vLow0, 832);
    checkOutput("frame0_period", fPeriod0, 832 * 9);
    checkOutput("rgb0_nonzero_per_frame", rgbFrame0, 640 * 6);
    checkOutput("pix_ce1_gap", pixGap1, 4);
    checkOutput("line1_period", linePeriod1, 56);
    checkOutput("hsync1_high", hHigh1, 8);
    checkOutput("vsync1_high_clks", vHigh1, 56);
    checkOutput("frame1_period", fPeriod1, 392);
    checkOutput("rgb1_lag", lag1, 16);
    checkOutput("blank_violations", blankViol, 0);

    // Random colours with occasional reset pulses.
    repeat (20000) applyStimulus(($urandom_range(0, 1999) != 0), 3'($urandom));
    reset = 1'b1;

    // Reset asserted for one clk in the middle of an active line.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (if0.x == 10'd300 && if0.y == 10'd3) found = 1'b1;
    end
    checkOutput("wait_mid_line", int'(found), 1);
    applyStimulus(1'b0, 3'b101);
    checkOutput("midrst_x0", int'(if0.x), 0);
    checkOutput("midrst_y0", int'(if0.y), 0);
    checkOutput("midrst_de0", int'(if0.de), 1);
    checkOutput("midrst_hsync0", int'(if0.hsync), 1);
    checkOutput("midrst_vsync0", int'(if0.vsync), 1);
    checkOutput("midrst_rgb0", int'(if0.rgb), 0);
    checkOutput("midrst_x1", int'(if1.x), 0);
    checkOutput("midrst_hsync1", int'(if1.hsync), 0);
    reset = 1'b1;

    // Wrap corner at the last pixel of the last line.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (if0.frame_strobe) found = 1'b1;
    end
    checkOutput("wait_frame_strobe", int'(found), 1);
    checkOutput("corner_line_strobe", int'(if0.line_strobe), 1);
    checkOutput("corner_x", int'(if0.x), 831);
    checkOutput("corner_y", int'(if0.y), 8);
    @(negedge clk);
    checkOutput("wrap_x", int'(if0.x), 0);
    checkOutput("wrap_y", int'(if0.y), 0);
    checkOutput("wrap_de", int'(if0.de), 1);
    checkOutput("wrap_frame_strobe", int'(if0.frame_strobe), 0);

    repeat (20) @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
